alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational 4-bit ALU (ops: 00 invert A, 01 A+B, 10 A-B, 11 double A) between two requesters. Round-robin arbitration with a valid/ready request handshake. Granted operands are registered, driven onto the ALU for one cycle, the ALU result is captured, and a one-cycle tagged response pulse is returned to the winner. Sits between the requesting datapath masters and the ALU instance.

Parameters:
WIDTH, 4, operand/result width; must match the ALU.
OPW, 2, opcode width (S select).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_a  in  WIDTH  requester 0 operand A.
req0_b  in  WIDTH  requester 0 operand B.
req0_op  in  OPW  requester 0 ALU select.
req0_ready  out  1  requester 0 request accepted this cycle.
resp0_valid  out  1  one-cycle pulse: resp_y holds requester 0 result.
req1_valid, req1_a, req1_b, req1_op, req1_ready, resp1_valid: same as above for requester 1.
resp_y  out  WIDTH  result bus, shared; qualified by resp0_valid/resp1_valid.
alu_a  out  WIDTH  to ALU A.
alu_b  out  WIDTH  to ALU B.
alu_s  out  OPW  to ALU S.
alu_y  in  WIDTH  from ALU Y, combinational.
busy  out  1  high in EXEC and RESP.

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE, rr pointer=0 (requester 0 preferred), operand/op/result/owner registers=0, all outputs 0. Reset mid-operation aborts the operation; no response pulse is issued.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: reqN_ready is combinational = (state==IDLE) & grantN. Only one valid -> grant it. Both valid -> grant the rr-pointer side. Transfer on valid&ready: latch a, b, op and owner; go to EXEC. No valid -> stay in IDLE.
- EXEC: alu_a/alu_b/alu_s driven from latched registers, stable for the whole cycle. At the clock edge, alu_y is captured into the result register; go to RESP.
- RESP: resp_y = result, resp<owner>_valid=1 for exactly one cycle, no backpressure. The rr pointer moves to the non-owner. Go to IDLE.
- Latency: accept at cycle T, response at T+2. Next accept no earlier than T+3, so sustained throughput is 1 op / 3 cycles.
- Outside EXEC, alu_a/b/s hold their last latched values. resp_y holds the last result. respN_valid=0.
- Arithmetic is done by the ALU, modulo 2^WIDTH. Carry and borrow are discarded and the block does not inspect the result.
- Requesters may drop valid before being granted; the block does no checking. Operands are sampled only at the transfer edge; later changes on reqN_* have no effect.
- A requester whose valid stays high wins at most every other grant while the other side is also valid. There is no starvation.
- busy=0 in IDLE.

Test Plan:
1. Reset, then req0 {A=3, op=00} alone -> req0_ready high in the same cycle, alu_a=3/alu_s=0 in EXEC, resp0_valid pulse at T+2 with resp_y=12, resp1_valid stays 0.
2. req1 {A=5, B=8, op=01}, then req1 {A=9, B=3, op=01} held back-to-back -> resp_y=13 then 12. Second accept occurs exactly 3 cycles after the first.
3. Both valid in the same cycle after reset: req0 {6,2,op=10}, req1 {10,11,op=10} -> req0 granted first (resp0, y=4), then req1 (resp1, y=15). req1_ready is never high while state!=IDLE.
4. Both valid continuously with op=11, req0 A=4, req1 A=7 -> grants alternate 0,1,0,1. Results alternate 8 and 14.
5. rst asserted during EXEC of req0 {A=3, op=00} -> no resp0_valid, all outputs 0 next cycle. After release, req1 {A=12, op=00} completes with resp_y=3 and req1 granted normally.
6. req0 changes a/b/op the cycle after transfer -> EXEC still drives the original latched values, and the response reflects the original values.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Purpose: bundles both requester handshakes, the shared response bus and the ALU hookup.
// Latency: none, wiring only.
// Backpressure: reqN_ready qualifies reqN_valid; responses are pulses with no backpressure.
interface alu_share_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int OPW   = 2
);
   // requester 0
   logic             req0_valid;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic             req0_ready;
   logic             resp0_valid;
   // requester 1
   logic             req1_valid;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic             req1_ready;
   logic             resp1_valid;
   // shared result bus
   logic [WIDTH-1:0] resp_y;
   // ALU connection
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_s;
   logic [WIDTH-1:0] alu_y;
   // status
   logic             busy;

   // environment side: requesters plus the ALU instance
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output alu_y,
      input  req0_ready, resp0_valid, req1_ready, resp1_valid,
      input  resp_y, alu_a, alu_b, alu_s, busy
   );

   // arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  alu_y,
      output req0_ready, resp0_valid, req1_ready, resp1_valid,
      output resp_y, alu_a, alu_b, alu_s, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters.
// Latency: accept at T, operands on ALU at T+1, tagged response pulse at T+2; one op per 3 cycles.
// Backpressure: reqN_ready only in IDLE for the granted side; response pulse cannot be stalled.
module alu_share_arbiter #(
   parameter int WIDTH = 4,
   parameter int OPW   = 2
) (
   input logic                clk,
   input logic                rst,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rr_q, rr_d;          // 0: requester 0 preferred on a tie
   logic             owner_q, owner_d;    // requester that owns the operation in flight
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic grant0;
   logic grant1;

   // Round-robin grant: a lone requester always wins, a tie goes to the rr side.
   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_q);
      grant1 = bus.req1_valid & (~bus.req0_valid |  rr_q);
   end

   // State and datapath registers with synchronous reset; reset aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         owner_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   // Next state: IDLE waits for a grant, then one EXEC cycle and one RESP cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant0 | grant1) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: latch the winner's request, capture the ALU, then rotate priority.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      owner_d  = owner_q;
      result_d = result_q;
      rr_d     = rr_q;
      unique case (state_q)
         IDLE: begin
            // ready equals grant in IDLE, so a grant is a completed transfer
            if (grant0) begin
               a_d     = bus.req0_a;
               b_d     = bus.req0_b;
               op_d    = bus.req0_op;
               owner_d = 1'b0;
            end else if (grant1) begin
               a_d     = bus.req1_a;
               b_d     = bus.req1_b;
               op_d    = bus.req1_op;
               owner_d = 1'b1;
            end
         end
         EXEC: result_d = bus.alu_y;
         RESP: rr_d     = ~owner_q;
         default: ;
      endcase
   end

   // Outputs: ALU operands and result bus come straight from registers and hold between ops.
   always_comb begin
      bus.req0_ready  = (state_q == IDLE) & grant0;
      bus.req1_ready  = (state_q == IDLE) & grant1;
      bus.resp0_valid = (state_q == RESP) & ~owner_q;
      bus.resp1_valid = (state_q == RESP) &  owner_q;
      bus.resp_y      = result_q;
      bus.alu_a       = a_q;
      bus.alu_b       = b_q;
      bus.alu_s       = op_q;
      bus.busy        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: directed bench for alu_share_arbiter with a response scoreboard.
// Latency: expects responses two cycles after each accept.
// Backpressure: requesters hold valid until ready as each step requires.
module tb_alu_share_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_share_arbiter_if #(.WIDTH(4), .OPW(2)) bus ();

   alu_share_arbiter #(.WIDTH(4), .OPW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU sitting on the other side of the arbiter.
   always_comb begin
      case (bus.alu_s)
         2'd0:    bus.alu_y = ~bus.alu_a;
         2'd1:    bus.alu_y = bus.alu_a + bus.alu_b;
         2'd2:    bus.alu_y = bus.alu_a - bus.alu_b;
         default: bus.alu_y = {bus.alu_a[2:0], 1'b0};
      endcase
   end

   int compared   = 0;
   int mismatched = 0;
   logic mon_en   = 1'b0;

   // scoreboard entries are {owner, y}
   logic [4:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Response monitor: every pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (mon_en && (bus.resp0_valid || bus.resp1_valid)) begin
         logic [4:0] e;
         compared++;
         assert (!(bus.resp0_valid && bus.resp1_valid) && exp_q.size() > 0)
         else begin
            mismatched++;
            $error("FAIL resp_unexpected observed=r0:%0d r1:%0d y:%0d expected=no_pulse",
                   bus.resp0_valid, bus.resp1_valid, bus.resp_y);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            assert ({bus.resp1_valid, bus.resp_y} === e)
            else begin
               mismatched++;
               $error("FAIL resp_data observed=owner%0d y=%0d expected=owner%0d y=%0d",
                      bus.resp1_valid, bus.resp_y, e[4], e[3:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      @(negedge clk);
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic idle_reqs();
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
   endtask

   initial begin
      idle_reqs();
      rst = 1'b1;
      tick();
      tick();
      mon_en = 1'b1;
      // reset state
      @(negedge clk);
      chk("rst_busy",   bus.busy, 0);
      chk("rst_ready",  {bus.req0_ready, bus.req1_ready}, 0);
      chk("rst_resp",   {bus.resp0_valid, bus.resp1_valid}, 0);
      chk("rst_alu",    {bus.alu_a, bus.alu_b, bus.alu_s}, 0);
      chk("rst_resp_y", bus.resp_y, 0);
      tick();
      rst = 1'b0;
      tick();

      // 1: lone req0 invert 3 -> 12
      bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_op = 2'd0;
      exp_q.push_back({1'b0, 4'd12});
      @(negedge clk);
      chk("t1_ready0", bus.req0_ready, 1);
      chk("t1_ready1", bus.req1_ready, 0);
      chk("t1_idle_busy", bus.busy, 0);
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("t1_exec_busy", bus.busy, 1);
      chk("t1_alu_a", bus.alu_a, 3);
      chk("t1_alu_s", bus.alu_s, 0);
      chk("t1_no_early_resp", bus.resp0_valid, 0);
      tick();
      @(negedge clk);
      chk("t1_resp0", bus.resp0_valid, 1);
      chk("t1_resp1", bus.resp1_valid, 0);
      chk("t1_resp_y", bus.resp_y, 12);
      chk("t1_resp_busy", bus.busy, 1);
      tick();
      @(negedge clk);
      chk("t1_pulse_end", bus.resp0_valid, 0);
      chk("t1_hold_y", bus.resp_y, 12);
      chk("t1_back_idle", bus.busy, 0);
      drain("t1_drain");

      // 2: req1 back-to-back adds, second accept exactly 3 cycles later
      tick();
      bus.req1_valid = 1'b1; bus.req1_a = 4'd5; bus.req1_b = 4'd8; bus.req1_op = 2'd1;
      exp_q.push_back({1'b1, 4'd13});
      exp_q.push_back({1'b1, 4'd12});
      @(negedge clk);
      chk("t2_accept1", bus.req1_ready, 1);
      tick();
      bus.req1_a = 4'd9; bus.req1_b = 4'd3;
      @(negedge clk);
      chk("t2_exec_ready", bus.req1_ready, 0);
      tick();
      @(negedge clk);
      chk("t2_resp_ready", bus.req1_ready, 0);
      tick();
      @(negedge clk);
      chk("t2_accept2", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      drain("t2_drain");

      // 3: simultaneous after reset, req0 wins first
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 4'd6;  bus.req0_b = 4'd2;  bus.req0_op = 2'd2;
      bus.req1_valid = 1'b1; bus.req1_a = 4'd10; bus.req1_b = 4'd11; bus.req1_op = 2'd2;
      exp_q.push_back({1'b0, 4'd4});
      exp_q.push_back({1'b1, 4'd15});
      @(negedge clk);
      chk("t3_ready0", bus.req0_ready, 1);
      chk("t3_ready1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("t3_exec_ready1", bus.req1_ready, 0);
      tick();
      @(negedge clk);
      chk("t3_resp_ready1", bus.req1_ready, 0);
      tick();
      @(negedge clk);
      chk("t3_ready1_idle", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      drain("t3_drain");

      // 4: both held with op=11, grants alternate 0,1,0,1
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 4'd4; bus.req0_b = 4'd0; bus.req0_op = 2'd3;
      bus.req1_valid = 1'b1; bus.req1_a = 4'd7; bus.req1_b = 4'd0; bus.req1_op = 2'd3;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) exp_q.push_back({1'b0, 4'd8});
         else            exp_q.push_back({1'b1, 4'd14});
         @(negedge clk);
         chk($sformatf("t4_grant%0d", i), {bus.req1_ready, bus.req0_ready},
             (i % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         tick();
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      drain("t4_drain");

      // 5: reset during EXEC aborts req0, then req1 completes
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd0; bus.req0_op = 2'd0;
      @(negedge clk);
      chk("t5_ready0", bus.req0_ready, 1);
      tick();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("t5_exec_busy", bus.busy, 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t5_abort_resp", {bus.resp0_valid, bus.resp1_valid}, 0);
      chk("t5_abort_busy", bus.busy, 0);
      chk("t5_abort_alu", {bus.alu_a, bus.alu_b, bus.alu_s}, 0);
      chk("t5_abort_y", bus.resp_y, 0);
      tick();
      rst = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 4'd12; bus.req1_b = 4'd0; bus.req1_op = 2'd0;
      exp_q.push_back({1'b1, 4'd3});
      @(negedge clk);
      chk("t5_ready1", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      drain("t5_drain");

      // 6: operands change right after transfer; latched values must win
      tick();
      bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd6; bus.req0_op = 2'd1;
      exp_q.push_back({1'b0, 4'd11});
      @(negedge clk);
      chk("t6_ready0", bus.req0_ready, 1);
      tick();
      bus.req0_valid = 1'b0; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_op = 2'd3;
      @(negedge clk);
      chk("t6_alu_a", bus.alu_a, 5);
      chk("t6_alu_b", bus.alu_b, 6);
      chk("t6_alu_s", bus.alu_s, 1);
      drain("t6_drain");

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
